// File: rtl/apb_gpio_uart_rx_pkg.sv
// Shared definitions for the APB GPIO / UART-RX subsystem.
//   - address map of the host-visible registers
//   - APB master and UART receiver state encodings
//   - addr_mapped(): true for any address that starts a bus transfer
package apb_gpio_uart_rx_pkg;

  localparam logic [7:0] ADDR_GPIO_IN  = 8'h81;
  localparam logic [7:0] ADDR_GPIO_OUT = 8'h82;
  localparam logic [7:0] ADDR_GPIO_DIR = 8'h83;
  localparam logic [7:0] ADDR_UART_TX  = 8'h02;
  localparam logic [7:0] ADDR_UART_RX  = 8'h41;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2
  } master_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic addr_mapped(input logic [7:0] a);
    return (a == ADDR_GPIO_IN)  || (a == ADDR_GPIO_OUT) || (a == ADDR_GPIO_DIR) ||
           (a == ADDR_UART_TX)  || (a == ADDR_UART_RX);
  endfunction

endpackage

// File: rtl/apb_gpio_uart_rx_uart_rx_core.sv
// 8N1 UART receiver, LSB first, always listening.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   rx_i     : serial line, idle high (asynchronous, synchronised here)
//   byte_o   : shift register contents; valid when valid_o is high
//   valid_o  : one-cycle pulse when a frame with a good stop bit completes
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the line
// RX_START | half-bit wait, then confirm start bit (else treat as glitch)
// RX_DATA  | sample 8 data bits at bit centres
// RX_STOP  | sample stop bit; 1 = deliver byte, 0 = framing error, drop
module uart_rx_core
  import apb_gpio_uart_rx_pkg::*;
#(
  parameter int C = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o
);

  localparam int              CW      = $clog2(C + 1);
  localparam logic [CW-1:0]   HALF_M1 = CW'(C / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(C - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic          tc;

  assign rx_s   = sync_q[1];
  assign tc     = (cnt_q == '0);
  assign byte_o = shift_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (tc) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (tc) begin
          // LSB arrives first and ends up in bit 0 after eight shifts
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (tc) begin
          valid_o = rx_s;
          state_d = RX_IDLE;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/apb_gpio_uart_rx.sv
// Host-driven APB master with an on-board GPIO slave and UART receiver.
//   PCLK/PRESETn              : clock, asynchronous active-low reset
//   tb_addr/tb_write_data     : host request; unmapped address = no request
//   READ_WRITE                : 1 = read, 0 = write
//   tb_read_data              : data of the last completed read
//   PSEL1/PSEL2/ENABLE/PWRITE/PADDR/PWDATA : exported APB bus
//   PREADY_EXT                : ready from the external UART TX slave
//   gpio_in/gpio_out/gpio_dir : GPIO pins (dir 1 = output)
//   Rx_Serial/Rx_Done/rx_parallel : UART line, sticky byte flag, last byte
//
// state    | meaning
// M_IDLE   | no transfer; bus address/data hold last value
// M_SETUP  | first APB phase, request latched, ENABLE low
// M_ACCESS | ENABLE high, wait for PREADY
module apb_gpio_uart_rx
  import apb_gpio_uart_rx_pkg::*;
#(
  parameter int C = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [7:0] tb_addr,
  input  logic [7:0] tb_write_data,
  input  logic       READ_WRITE,
  input  logic [7:0] gpio_in,
  input  logic       Rx_Serial,
  input  logic       PREADY_EXT,
  output logic [7:0] tb_read_data,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       ENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  output logic [7:0] gpio_out,
  output logic [7:0] gpio_dir,
  output logic       Rx_Done,
  output logic [7:0] rx_parallel
);

  master_state_e state_q, state_d;
  logic [7:0]    paddr_q, pwdata_q, rdata_q, out_q, dir_q, rx_byte_q;
  logic          pwrite_q, rx_done_q;
  logic          active, gpio_ready, rx_ready, pready, xfer_done, rx_read_done;
  logic          rx_valid;
  logic [7:0]    rx_byte, gpio_rdata, prdata;

  uart_rx_core #(.C(C)) u_rx (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .rx_i   (Rx_Serial),
    .byte_o (rx_byte),
    .valid_o(rx_valid)
  );

  assign active       = (state_q != M_IDLE);
  assign PSEL1        = active & paddr_q[7];
  assign PSEL2        = active & ~paddr_q[7];
  assign ENABLE       = (state_q == M_ACCESS);
  assign PWRITE       = pwrite_q;
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;
  assign tb_read_data = rdata_q;
  assign gpio_dir     = dir_q;
  assign gpio_out     = out_q & dir_q;
  assign Rx_Done      = rx_done_q;
  assign rx_parallel  = rx_byte_q;

  // RX read stalls until a byte is waiting
  assign gpio_ready   = PSEL1 & ENABLE;
  assign rx_ready     = PSEL2 & ENABLE & ~pwrite_q & (paddr_q == ADDR_UART_RX) & rx_done_q;
  assign pready       = gpio_ready | rx_ready | PREADY_EXT;
  assign xfer_done    = ENABLE & pready;
  assign rx_read_done = xfer_done & ~pwrite_q & PSEL2 & (paddr_q == ADDR_UART_RX);

  always_comb begin
    gpio_rdata = 8'h00;
    case (paddr_q)
      ADDR_GPIO_IN:  gpio_rdata = (gpio_in & ~dir_q) | (out_q & dir_q);
      ADDR_GPIO_OUT: gpio_rdata = out_q;
      ADDR_GPIO_DIR: gpio_rdata = dir_q;
      default:       gpio_rdata = 8'h00;
    endcase
  end

  assign prdata = PSEL2 ? rx_byte_q : gpio_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE:   if (addr_mapped(tb_addr)) state_d = M_SETUP;
      M_SETUP:  state_d = M_ACCESS;
      M_ACCESS: if (pready) state_d = addr_mapped(tb_addr) ? M_SETUP : M_IDLE;
      default:  state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= M_IDLE;
      paddr_q  <= 8'h00;
      pwdata_q <= 8'h00;
      pwrite_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      // request is latched on every entry into SETUP, including back-to-back
      if (state_d == M_SETUP) begin
        paddr_q  <= tb_addr;
        pwdata_q <= tb_write_data;
        pwrite_q <= ~READ_WRITE;
      end
      if (xfer_done && !pwrite_q) rdata_q <= prdata;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_q <= 8'h00;
      dir_q <= 8'h00;
    end else if (xfer_done && pwrite_q && PSEL1) begin
      if (paddr_q == ADDR_GPIO_OUT) out_q <= pwdata_q;
      if (paddr_q == ADDR_GPIO_DIR) dir_q <= pwdata_q;
    end
  end

  // a byte landing in the same cycle as the read that clears the flag wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_byte_q <= 8'h00;
      rx_done_q <= 1'b0;
    end else begin
      if (rx_valid) rx_byte_q <= rx_byte;
      if (rx_valid)          rx_done_q <= 1'b1;
      else if (rx_read_done) rx_done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_gpio_uart_rx.sv
module tb_apb_gpio_uart_rx;

  localparam int CB = 4;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [7:0] tb_addr = 8'h00;
  logic [7:0] tb_write_data = 8'h00;
  logic       READ_WRITE = 1'b1;
  logic [7:0] gpio_in = 8'h00;
  logic       Rx_Serial = 1'b1;
  logic       PREADY_EXT = 1'b0;
  logic [7:0] tb_read_data, PADDR, PWDATA, gpio_out, gpio_dir, rx_parallel;
  logic       PSEL1, PSEL2, ENABLE, PWRITE, Rx_Done;

  int errors = 0;
  int checks = 0;
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_dir = 8'h00;
  logic [7:0] rx_hist[$];

  always #5 PCLK = ~PCLK;

  apb_gpio_uart_rx #(.C(CB)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .tb_addr(tb_addr), .tb_write_data(tb_write_data),
    .READ_WRITE(READ_WRITE), .gpio_in(gpio_in), .Rx_Serial(Rx_Serial), .PREADY_EXT(PREADY_EXT),
    .tb_read_data(tb_read_data), .PSEL1(PSEL1), .PSEL2(PSEL2), .ENABLE(ENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
    .Rx_Done(Rx_Done), .rx_parallel(rx_parallel)
  );

  // One host transfer; address is withdrawn after SETUP so it ends in IDLE.
  task automatic apb_xfer(input logic [7:0] a, input logic [7:0] wd, input logic rd, input int budget,
                          output logic setup_ok, output int acc, output logic tmo);
    @(negedge PCLK);
    tb_addr = a; tb_write_data = wd; READ_WRITE = rd;
    @(negedge PCLK);
    setup_ok = (PSEL1 === a[7]) && (PSEL2 === ~a[7]) && (ENABLE === 1'b0) &&
               (PADDR === a) && (PWDATA === wd) && (PWRITE === ~rd);
    tb_addr = 8'h00;
    acc = 0;
    do begin
      @(negedge PCLK);
      if (ENABLE === 1'b1) acc++;
    end while (ENABLE === 1'b1 && acc < budget);
    tmo = (ENABLE === 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge PCLK);
    Rx_Serial = 1'b0;
    repeat (CB) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      Rx_Serial = b[i];
      repeat (CB) @(negedge PCLK);
    end
    Rx_Serial = stop_bit;
    repeat (CB) @(negedge PCLK);
    Rx_Serial = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    checks++; if ({PSEL1, PSEL2, ENABLE, PWRITE, PADDR, PWDATA, tb_read_data} !== 28'h0) begin
      errors++; $display("FAIL reset_bus: got %h exp 0", {PSEL1, PSEL2, ENABLE, PWRITE, PADDR, PWDATA, tb_read_data}); end
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++; if ({gpio_out, gpio_dir, rx_parallel, Rx_Done} !== 25'h0) begin
      errors++; $display("FAIL reset_regs: got %h exp 0", {gpio_out, gpio_dir, rx_parallel, Rx_Done}); end
  endtask

  task automatic test_gpio_directed();
    logic s, t; int acc;
    apb_xfer(8'h83, 8'hF9, 1'b0, 20, s, acc, t);
    checks++; if (!(s && acc == 1 && !t)) begin errors++; $display("FAIL dir_write_phases: got setup=%0b access=%0d exp 1/1", s, acc); end
    m_dir = 8'hF9;
    apb_xfer(8'h82, 8'hF0, 1'b0, 20, s, acc, t);
    checks++; if (!(s && acc == 1 && !t)) begin errors++; $display("FAIL out_write_phases: got setup=%0b access=%0d exp 1/1", s, acc); end
    m_out = 8'hF0;
    checks++; if ({gpio_dir, gpio_out} !== 16'hF9F0) begin errors++; $display("FAIL gpio_pins: got %h exp F9F0", {gpio_dir, gpio_out}); end
    gpio_in = 8'hFF;
    apb_xfer(8'h81, 8'h00, 1'b1, 20, s, acc, t);
    checks++; if (tb_read_data !== 8'hF6) begin errors++; $display("FAIL gpio_in_read: got %h exp F6", tb_read_data); end
  endtask

  task automatic test_gpio_random();
    logic s, t; int acc, op; logic [7:0] wd, exp_rd, a;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 5);
      gpio_in = 8'($urandom);
      wd = 8'($urandom);
      a = (op == 0 || op == 4) ? 8'h82 : (op == 1 || op == 5) ? 8'h83 : 8'h81;
      apb_xfer(a, wd, (op >= 3), 20, s, acc, t);
      checks++; if (!(s && acc == 1 && !t)) begin errors++; $display("FAIL rnd_phases[%0d]: got setup=%0b access=%0d exp 1/1", i, s, acc); end
      if (op == 0) m_out = wd;
      if (op == 1) m_dir = wd;
      if (op >= 3) begin
        exp_rd = (a == 8'h82) ? m_out : (a == 8'h83) ? m_dir : ((gpio_in & ~m_dir) | (m_out & m_dir));
        checks++; if (tb_read_data !== exp_rd) begin errors++; $display("FAIL rnd_read[%0d] addr %h: got %h exp %h", i, a, tb_read_data, exp_rd); end
      end
      checks++; if ({gpio_dir, gpio_out} !== {m_dir, m_out & m_dir}) begin
        errors++; $display("FAIL rnd_pins[%0d]: got %h exp %h", i, {gpio_dir, gpio_out}, {m_dir, m_out & m_dir}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq; logic [7:0] pw2;
    @(negedge PCLK); tb_addr = 8'h82; tb_write_data = 8'h3C; READ_WRITE = 1'b0;
    @(negedge PCLK); seq[9:8] = {PSEL1, ENABLE}; tb_write_data = 8'hC3;
    @(negedge PCLK); seq[7:6] = {PSEL1, ENABLE};
    @(negedge PCLK); seq[5:4] = {PSEL1, ENABLE}; pw2 = PWDATA; tb_addr = 8'h00;
    @(negedge PCLK); seq[3:2] = {PSEL1, ENABLE};
    @(negedge PCLK); seq[1:0] = {PSEL1, ENABLE};
    m_out = 8'hC3;
    checks++; if (seq !== 10'b10_11_10_11_00) begin errors++; $display("FAIL b2b_phases: got %b exp 1011101100", seq); end
    checks++; if (pw2 !== 8'hC3) begin errors++; $display("FAIL b2b_pwdata: got %h exp C3", pw2); end
    checks++; if (gpio_out !== (m_out & m_dir) || PADDR !== 8'h82) begin
      errors++; $display("FAIL b2b_result: got out=%h paddr=%h exp %h/82", gpio_out, PADDR, m_out & m_dir); end
  endtask

  task automatic test_ext_wait();
    logic s, t; int acc, n, g; logic [9:0] bus;
    bus = '0;
    fork
      apb_xfer(8'h02, 8'hAA, 1'b0, 50, s, acc, t);
      begin
        n = 0; g = 0;
        while (n < 6 && g < 60) begin
          @(negedge PCLK); g++;
          if (ENABLE === 1'b1) begin n++; if (n == 3) bus = {PSEL2, PWRITE, PWDATA}; end
        end
        PREADY_EXT = 1'b1;
        @(negedge PCLK); PREADY_EXT = 1'b0;
      end
    join
    checks++; if (acc != 6 || t) begin errors++; $display("FAIL ext_access_len: got %0d exp 6", acc); end
    checks++; if (bus !== 10'h3AA) begin errors++; $display("FAIL ext_bus: got %h exp 3AA", bus); end
    checks++; if ({gpio_dir, gpio_out} !== {m_dir, m_out & m_dir}) begin errors++; $display("FAIL ext_gpio_untouched: got %h", {gpio_dir, gpio_out}); end
  endtask

  task automatic test_rx_read_stall();
    logic s, t; int acc, g;
    checks++; if (Rx_Done !== 1'b0) begin errors++; $display("FAIL stall_pre_done: got %b exp 0", Rx_Done); end
    fork
      apb_xfer(8'h41, 8'h00, 1'b1, 200, s, acc, t);
      begin
        g = 0;
        do begin @(negedge PCLK); g++; end while (ENABLE !== 1'b1 && g < 20);
        send_frame(8'hC5, 1'b1);
      end
    join
    repeat (CB) @(negedge PCLK);
    checks++; if (t || acc < 9 * CB || acc > 10 * CB + 6) begin errors++; $display("FAIL stall_len: got %0d exp %0d..%0d", acc, 9 * CB, 10 * CB + 6); end
    checks++; if ({tb_read_data, rx_parallel, Rx_Done} !== {8'hC5, 8'hC5, 1'b0}) begin
      errors++; $display("FAIL stall_data: got rd=%h rx=%h done=%b exp C5/C5/0", tb_read_data, rx_parallel, Rx_Done); end
    rx_hist.push_back(8'hC5);
  endtask

  task automatic test_rx_framing();
    logic s, t; int acc, g; logic [7:0] bad, good;
    bad = 8'($urandom); good = bad ^ 8'h96;
    fork
      apb_xfer(8'h41, 8'h00, 1'b1, 400, s, acc, t);
      begin
        g = 0;
        do begin @(negedge PCLK); g++; end while (ENABLE !== 1'b1 && g < 20);
        send_frame(bad, 1'b0);
        repeat (2 * CB) @(negedge PCLK);
        checks++; if ({ENABLE, Rx_Done, rx_parallel} !== {1'b1, 1'b0, rx_hist[$]}) begin
          errors++; $display("FAIL framing_hold: got en=%b done=%b rx=%h exp 1/0/%h", ENABLE, Rx_Done, rx_parallel, rx_hist[$]); end
        send_frame(good, 1'b1);
      end
    join
    repeat (CB) @(negedge PCLK);
    rx_hist.push_back(good);
    checks++; if (t || {tb_read_data, Rx_Done} !== {good, 1'b0}) begin
      errors++; $display("FAIL framing_release: got rd=%h done=%b exp %h/0", tb_read_data, Rx_Done, good); end
  endtask

  task automatic test_rx_random();
    logic s, t; int acc; logic [7:0] b;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1);
        repeat (CB) @(negedge PCLK);
        rx_hist.push_back(b);
        checks++; if ({rx_parallel, Rx_Done} !== {rx_hist[$], 1'b1}) begin
          errors++; $display("FAIL rx_byte[%0d.%0d]: got %h/%b exp %h/1", r, k, rx_parallel, Rx_Done, rx_hist[$]); end
      end
      apb_xfer(8'h41, 8'h00, 1'b1, 20, s, acc, t);
      checks++; if (acc != 1 || t || {tb_read_data, Rx_Done} !== {rx_hist[$], 1'b0}) begin
        errors++; $display("FAIL rx_read[%0d]: got %h/%b acc=%0d exp %h/0 acc=1", r, tb_read_data, Rx_Done, acc, rx_hist[$]); end
    end
  endtask

  task automatic test_rx_collision();
    logic s, t; int acc, n_old, n_new; logic [7:0] a, b;
    n_old = 0; n_new = 0;
    for (int d = 30; d <= 46; d++) begin
      a = 8'($urandom); b = a ^ 8'h5A;
      send_frame(a, 1'b1);
      repeat (CB) @(negedge PCLK);
      fork
        send_frame(b, 1'b1);
        begin repeat (d) @(negedge PCLK); apb_xfer(8'h41, 8'h00, 1'b1, 20, s, acc, t); end
      join
      repeat (CB) @(negedge PCLK);
      if (tb_read_data === a) begin
        n_old++;
        checks++; if ({Rx_Done, rx_parallel} !== {1'b1, b}) begin
          errors++; $display("FAIL collide_old[%0d]: got done=%b rx=%h exp 1/%h", d, Rx_Done, rx_parallel, b); end
      end else begin
        n_new++;
        checks++; if ({tb_read_data, Rx_Done, rx_parallel} !== {b, 1'b0, b}) begin
          errors++; $display("FAIL collide_new[%0d]: got rd=%h done=%b rx=%h exp %h/0/%h", d, tb_read_data, Rx_Done, rx_parallel, b, b); end
      end
    end
    checks++; if (n_old == 0 || n_new == 0) begin errors++; $display("FAIL collide_sweep: got old=%0d new=%0d exp both nonzero", n_old, n_new); end
  endtask

  task automatic test_reset_mid_access();
    logic s, t; int acc;
    apb_xfer(8'h83, 8'hFF, 1'b0, 20, s, acc, t);
    m_dir = 8'hFF;
    @(negedge PCLK); tb_addr = 8'h82; tb_write_data = 8'h5A; READ_WRITE = 1'b0;
    @(negedge PCLK); tb_addr = 8'h00;
    @(negedge PCLK);
    checks++; if (ENABLE !== 1'b1) begin errors++; $display("FAIL mid_access_reach: got %b exp 1", ENABLE); end
    PRESETn = 1'b0;
    #1;
    checks++; if ({PSEL1, PSEL2, ENABLE, PWRITE, PADDR, PWDATA, gpio_out, gpio_dir} !== 36'h0) begin
      errors++; $display("FAIL mid_reset_bus: got %h exp 0", {PSEL1, PSEL2, ENABLE, PWRITE, PADDR, PWDATA, gpio_out, gpio_dir}); end
    @(negedge PCLK); PRESETn = 1'b1;
    m_out = 8'h00; m_dir = 8'h00;
    apb_xfer(8'h82, 8'h00, 1'b1, 20, s, acc, t);
    checks++; if ({tb_read_data, gpio_out} !== {m_out, m_out & m_dir}) begin
      errors++; $display("FAIL mid_reset_nowrite: got %h exp 0000", {tb_read_data, gpio_out}); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gpio_directed();
    test_gpio_random();
    test_back_to_back();
    test_ext_wait();
    test_rx_read_stall();
    test_rx_framing();
    test_rx_random();
    test_rx_collision();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
